// File: rtl/evt_window_scanner.sv
// evt_window_scanner: emits one data-path event per pixel of a latched 2D
// window, raster order (x inner, y outer), over a valid/ready stream source.
// The stream port is carried as flat signals: valid, xid, yid out and ready
// in. All other event fields of the stream are constant zero, so they are
// not carried here.
// Optional feature: define SNE_SCAN_EVT_COUNT_EN to build evt_cnt_o, a
// saturating 32-bit count of transferred events.
module evt_window_scanner #(
  parameter int unsigned XID_W = 8,
  parameter int unsigned YID_W = 8
) (
  input  logic             engine_clk_i,
  input  logic             engine_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [XID_W-1:0] lbound_x_i,
  input  logic [XID_W-1:0] ubound_x_i,
  input  logic [YID_W-1:0] lbound_y_i,
  input  logic [YID_W-1:0] ubound_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
`ifdef SNE_SCAN_EVT_COUNT_EN
  output logic [31:0]      evt_cnt_o,
`endif
  output logic             evt_dp_stream_scan_src_valid_o,
  output logic [XID_W-1:0] evt_dp_stream_scan_src_xid_o,
  output logic [YID_W-1:0] evt_dp_stream_scan_src_yid_o,
  input  logic             evt_dp_stream_scan_src_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XID_W-1:0] lbx_q, lbx_d, ubx_q, ubx_d, x_q, x_d;
  logic [YID_W-1:0] lby_q, lby_d, uby_q, uby_d, y_q, y_d;
  logic             abort_pend_q, abort_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             last_beat;
  logic             end_scan;
`ifdef SNE_SCAN_EVT_COUNT_EN
  logic [31:0]      cnt_q, cnt_d;
`endif

  // Valid comes straight from a flop, so it never depends on ready.
  assign xfer      = busy_q && evt_dp_stream_scan_src_ready_i;
  assign last_beat = (x_q == ubx_q) && (y_q == uby_q);
  assign end_scan  = last_beat || abort_pend_q || abort_i;

  // Next-state, window bookkeeping and output flags.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    lbx_d        = lbx_q;
    ubx_d        = ubx_q;
    lby_d        = lby_q;
    uby_d        = uby_q;
    x_d          = x_q;
    y_d          = y_q;
    abort_pend_d = abort_pend_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
`ifdef SNE_SCAN_EVT_COUNT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          lbx_d        = lbound_x_i;
          ubx_d        = ubound_x_i;
          lby_d        = lbound_y_i;
          uby_d        = ubound_y_i;
          x_d          = lbound_x_i;
          y_d          = lbound_y_i;
          abort_pend_d = 1'b0;
`ifdef SNE_SCAN_EVT_COUNT_EN
          cnt_d        = '0;
`endif
          if ((lbound_x_i > ubound_x_i) || (lbound_y_i > ubound_y_i)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (xfer) begin
          if (end_scan) begin
            // Coordinates freeze on the final beat, so all-ones bounds
            // never step a counter past its range.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (x_q == ubx_q) begin
            x_d = lbx_q;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
`ifdef SNE_SCAN_EVT_COUNT_EN
    if (xfer && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
`endif
  end

  // State and datapath registers; reset drops any in-flight beat at once.
  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) begin
      state_q      <= IDLE;
      lbx_q        <= '0;
      ubx_q        <= '0;
      lby_q        <= '0;
      uby_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values from
      // before the edge, independent of statement order.
      state_q      <= state_d;
      lbx_q        <= lbx_d;
      ubx_q        <= ubx_d;
      lby_q        <= lby_d;
      uby_q        <= uby_d;
      x_q          <= x_d;
      y_q          <= y_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef SNE_SCAN_EVT_COUNT_EN
  // Saturating count of transferred events.
  always_ff @(posedge engine_clk_i or negedge engine_rst_ni) begin
    if (!engine_rst_ni) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign evt_cnt_o = cnt_q;
`endif

  assign busy_o                         = busy_q;
  assign done_o                         = done_q;
  assign err_o                          = err_q;
  assign evt_dp_stream_scan_src_valid_o = busy_q;
  assign evt_dp_stream_scan_src_xid_o   = x_q;
  assign evt_dp_stream_scan_src_yid_o   = y_q;

endmodule

// File: tb/tb_evt_window_scanner.sv
// Self-checking bench for evt_window_scanner: directed windows plus random
// windows and random ready, compared against a raster-order beat list.
module tb_evt_window_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] lbx = '0, ubx = '0, lby = '0, uby = '0;
  logic       busy, done, err, valid;
  logic [7:0] xid, yid;
`ifdef SNE_SCAN_EVT_COUNT_EN
  logic [31:0] evt_cnt;
`endif

  always #5 clk = ~clk;

  evt_window_scanner #(.XID_W(8), .YID_W(8)) dut (
    .engine_clk_i                   (clk),
    .engine_rst_ni                  (rst_n),
    .start_i                        (start),
    .abort_i                        (abort),
    .lbound_x_i                     (lbx),
    .ubound_x_i                     (ubx),
    .lbound_y_i                     (lby),
    .ubound_y_i                     (uby),
    .busy_o                         (busy),
    .done_o                         (done),
    .err_o                          (err),
`ifdef SNE_SCAN_EVT_COUNT_EN
    .evt_cnt_o                      (evt_cnt),
`endif
    .evt_dp_stream_scan_src_valid_o (valid),
    .evt_dp_stream_scan_src_xid_o   (xid),
    .evt_dp_stream_scan_src_yid_o   (yid),
    .evt_dp_stream_scan_src_ready_i (ready)
  );

  typedef struct {
    int x;
    int y;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: every (x,y) of the window, x inner, y outer.
  function automatic void build_exp(input int lx, input int ux,
                                    input int ly, input int uy);
    exp_q.delete();
    for (int y = ly; y <= uy; y++)
      for (int x = lx; x <= ux; x++)
        exp_q.push_back('{x: x, y: y});
  endfunction

  task automatic compare_beats(input int n_exp);
    check("n_beats", got_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
      check($sformatf("beat%0d_x", i), got_q[i].x, exp_q[i].x);
      check($sformatf("beat%0d_y", i), got_q[i].y, exp_q[i].y);
    end
  endtask

  task automatic check_cnt(input int exp);
`ifdef SNE_SCAN_EVT_COUNT_EN
    check("evt_cnt", evt_cnt, exp);
`endif
  endtask

  // Pulses start for one edge; bound inputs are scrambled afterwards.
  task automatic start_scan(input int lx, input int ux, input int ly, input int uy);
    @(negedge clk);
    lbx = 8'(lx); ubx = 8'(ux); lby = 8'(ly); uby = 8'(uy);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lbx = 8'($urandom); ubx = 8'($urandom); lby = 8'($urandom); uby = 8'($urandom);
  endtask

  // mode 0: ready high; 1: random ready; 2: abort while beat 4 is stalled.
  task automatic run_scan(input int mode, output int done_cyc);
    bit         pend_stall = 0;
    bit         saw_done = 0;
    bit         aborted = 0;
    int         stall = 0;
    int         last_xfer = -10;
    logic [7:0] px = '0, py = '0;
    got_q.delete();
    done_cyc = -1;
    for (int cyc = 1; cyc <= 400 && !saw_done; cyc++) begin
      @(negedge clk);
      abort = 1'b0;
      if (cyc == 1) begin
        check("first_valid", valid, 1);
        check("first_busy", busy, 1);
        check("first_err", err, 0);
      end
      if (pend_stall) begin
        check("hold_valid", valid, 1);
        check("hold_x", xid, px);
        check("hold_y", yid, py);
      end
      if (done) begin
        saw_done = 1;
        done_cyc = cyc;
        check("done_after_last", cyc, last_xfer + 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", valid, 0);
        pend_stall = 0;
      end else begin
        case (mode)
          0: ready = 1'b1;
          1: ready = 1'($urandom_range(0, 1));
          default: begin
            if (!aborted && got_q.size() == 3 && valid) begin
              aborted = 1;
              abort = 1'b1;
              ready = 1'b0;
              stall = 3;
            end else if (stall > 0) begin
              ready = 1'b0;
              stall--;
            end else begin
              ready = 1'b1;
            end
          end
        endcase
        if (valid && ready) begin
          got_q.push_back('{x: int'(xid), y: int'(yid)});
          last_xfer = cyc;
        end
        pend_stall = valid && !ready;
        px = xid;
        py = yid;
      end
    end
    if (!saw_done) check("done_timeout", 0, 1);
  endtask

  task automatic do_window(input int lx, input int ux, input int ly, input int uy,
                           input int mode);
    int dc;
    start_scan(lx, ux, ly, uy);
    if (lx > ux || ly > uy) begin
      @(negedge clk);
      check("inv_err", err, 1);
      check("inv_done", done, 1);
      check("inv_busy", busy, 0);
      check("inv_valid", valid, 0);
      @(negedge clk);
      check("inv_done_gone", done, 0);
      check("inv_err_sticky", err, 1);
      check("inv_no_beat", valid, 0);
      check_cnt(0);
    end else begin
      build_exp(lx, ux, ly, uy);
      run_scan(mode, dc);
      compare_beats(exp_q.size());
      if (mode == 0) check("consecutive", dc, exp_q.size() + 1);
      check_cnt(exp_q.size());
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int dc;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_xid", xid, 0);
    check("rst_yid", yid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check_cnt(0);
    rst_n = 1'b1;

    do_window(2, 4, 5, 6, 0);
    do_window(2, 4, 5, 6, 1);
    do_window(255, 255, 254, 255, 0);
    do_window(7, 3, 0, 0, 0);
    do_window(2, 4, 5, 6, 0);
    do_window(0, 0, 9, 2, 0);

    // Abort while beat 4 is stalled: it still completes, then the scan ends.
    start_scan(0, 9, 0, 9);
    build_exp(0, 9, 0, 9);
    run_scan(2, dc);
    compare_beats(4);
    check_cnt(4);

    // Reset in the middle of a scan.
    start_scan(0, 9, 0, 9);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_xid", xid, 0);
    check("mid_rst_yid", yid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check_cnt(0);
    @(negedge clk);
    rst_n = 1'b1;
    do_window(3, 5, 1, 2, 0);

    // Random windows, some deliberately inverted, with random ready.
    for (int i = 0; i < 8; i++) begin
      int bx, by, wx, wy;
      bx = $urandom_range(0, 252);
      by = $urandom_range(0, 252);
      wx = $urandom_range(0, 3);
      wy = $urandom_range(0, 3);
      if (i % 3 == 2) do_window(bx + wx + 1, bx, by, by + wy, 1);
      else            do_window(bx, bx + wx, by, by + wy, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
